// File: rtl/conv2_window_buf.sv
// Sliding 5x5x3 window generator for the conv2 stage.
// Turns a raster pixel stream into stride-1, unpadded windows. Each channel has a
// shift chain that spans four full rows plus five pixels. The window is taken from
// that chain with the incoming pixel in front, so a window appears one cycle after
// the beat that completes it.
module conv2_window_buf #(
    parameter int unsigned WIDTH     = 12,
    parameter int unsigned HEIGHT    = 12,
    parameter int unsigned DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic [DATA_BITS-1:0] data_in1,
    input  logic [DATA_BITS-1:0] data_in2,
    input  logic [DATA_BITS-1:0] data_in3,
    output logic [DATA_BITS-1:0] data_out1_0,
    output logic [DATA_BITS-1:0] data_out1_1,
    output logic [DATA_BITS-1:0] data_out1_2,
    output logic [DATA_BITS-1:0] data_out1_3,
    output logic [DATA_BITS-1:0] data_out1_4,
    output logic [DATA_BITS-1:0] data_out1_5,
    output logic [DATA_BITS-1:0] data_out1_6,
    output logic [DATA_BITS-1:0] data_out1_7,
    output logic [DATA_BITS-1:0] data_out1_8,
    output logic [DATA_BITS-1:0] data_out1_9,
    output logic [DATA_BITS-1:0] data_out1_10,
    output logic [DATA_BITS-1:0] data_out1_11,
    output logic [DATA_BITS-1:0] data_out1_12,
    output logic [DATA_BITS-1:0] data_out1_13,
    output logic [DATA_BITS-1:0] data_out1_14,
    output logic [DATA_BITS-1:0] data_out1_15,
    output logic [DATA_BITS-1:0] data_out1_16,
    output logic [DATA_BITS-1:0] data_out1_17,
    output logic [DATA_BITS-1:0] data_out1_18,
    output logic [DATA_BITS-1:0] data_out1_19,
    output logic [DATA_BITS-1:0] data_out1_20,
    output logic [DATA_BITS-1:0] data_out1_21,
    output logic [DATA_BITS-1:0] data_out1_22,
    output logic [DATA_BITS-1:0] data_out1_23,
    output logic [DATA_BITS-1:0] data_out1_24,
    output logic [DATA_BITS-1:0] data_out2_0,
    output logic [DATA_BITS-1:0] data_out2_1,
    output logic [DATA_BITS-1:0] data_out2_2,
    output logic [DATA_BITS-1:0] data_out2_3,
    output logic [DATA_BITS-1:0] data_out2_4,
    output logic [DATA_BITS-1:0] data_out2_5,
    output logic [DATA_BITS-1:0] data_out2_6,
    output logic [DATA_BITS-1:0] data_out2_7,
    output logic [DATA_BITS-1:0] data_out2_8,
    output logic [DATA_BITS-1:0] data_out2_9,
    output logic [DATA_BITS-1:0] data_out2_10,
    output logic [DATA_BITS-1:0] data_out2_11,
    output logic [DATA_BITS-1:0] data_out2_12,
    output logic [DATA_BITS-1:0] data_out2_13,
    output logic [DATA_BITS-1:0] data_out2_14,
    output logic [DATA_BITS-1:0] data_out2_15,
    output logic [DATA_BITS-1:0] data_out2_16,
    output logic [DATA_BITS-1:0] data_out2_17,
    output logic [DATA_BITS-1:0] data_out2_18,
    output logic [DATA_BITS-1:0] data_out2_19,
    output logic [DATA_BITS-1:0] data_out2_20,
    output logic [DATA_BITS-1:0] data_out2_21,
    output logic [DATA_BITS-1:0] data_out2_22,
    output logic [DATA_BITS-1:0] data_out2_23,
    output logic [DATA_BITS-1:0] data_out2_24,
    output logic [DATA_BITS-1:0] data_out3_0,
    output logic [DATA_BITS-1:0] data_out3_1,
    output logic [DATA_BITS-1:0] data_out3_2,
    output logic [DATA_BITS-1:0] data_out3_3,
    output logic [DATA_BITS-1:0] data_out3_4,
    output logic [DATA_BITS-1:0] data_out3_5,
    output logic [DATA_BITS-1:0] data_out3_6,
    output logic [DATA_BITS-1:0] data_out3_7,
    output logic [DATA_BITS-1:0] data_out3_8,
    output logic [DATA_BITS-1:0] data_out3_9,
    output logic [DATA_BITS-1:0] data_out3_10,
    output logic [DATA_BITS-1:0] data_out3_11,
    output logic [DATA_BITS-1:0] data_out3_12,
    output logic [DATA_BITS-1:0] data_out3_13,
    output logic [DATA_BITS-1:0] data_out3_14,
    output logic [DATA_BITS-1:0] data_out3_15,
    output logic [DATA_BITS-1:0] data_out3_16,
    output logic [DATA_BITS-1:0] data_out3_17,
    output logic [DATA_BITS-1:0] data_out3_18,
    output logic [DATA_BITS-1:0] data_out3_19,
    output logic [DATA_BITS-1:0] data_out3_20,
    output logic [DATA_BITS-1:0] data_out3_21,
    output logic [DATA_BITS-1:0] data_out3_22,
    output logic [DATA_BITS-1:0] data_out3_23,
    output logic [DATA_BITS-1:0] data_out3_24,
    output logic                 valid_out_buf,
    output logic                 frame_done
);

    localparam int unsigned ChainLen = 4 * WIDTH + 5;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [CW-1:0] ColLast = CW'(WIDTH - 1);
    localparam logic [RW-1:0] RowLast = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] ColMin  = CW'(4);
    localparam logic [RW-1:0] RowMin  = RW'(4);

    // chain_d is the full 4*WIDTH+5 chain as it looks after the current beat: entry 0 is the
    // incoming pixel. Only entries 0..ChainLen-2 need storing, because the oldest tap is read
    // here before it would be shifted in.
    logic [DATA_BITS-1:0] din     [3];
    logic [DATA_BITS-1:0] chain_q [3][ChainLen-1];
    logic [DATA_BITS-1:0] chain_d [3][ChainLen];
    logic [DATA_BITS-1:0] win_q   [3][25];
    logic [DATA_BITS-1:0] win_d   [3][25];

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          valid_q, done_q;
    logic          win_hit, frame_end;

    // Gather the channel inputs and build the post-shift view of each chain.
    always_comb begin
        din[0] = data_in1;
        din[1] = data_in2;
        din[2] = data_in3;
        for (int ch = 0; ch < 3; ch++) begin
            chain_d[ch][0] = din[ch];
            for (int i = 1; i < ChainLen; i++) begin
                chain_d[ch][i] = chain_q[ch][i-1];
            end
        end
    end

    // Window tap K = r*5+c sits (4-r) rows and (4-c) pixels behind the incoming pixel.
    always_comb begin
        for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < 25; k++) begin
                win_d[ch][k] = chain_d[ch][(4 - k / 5) * WIDTH + (4 - k % 5)];
            end
        end
    end

    // Raster position of the next beat, and whether this beat closes a window.
    always_comb begin
        col_d = col_q + 1'b1;
        row_d = row_q;
        if (col_q == ColLast) begin
            col_d = '0;
            row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
        end
        win_hit   = (row_q >= RowMin) && (col_q >= ColMin);
        frame_end = (row_q == RowLast) && (col_q == ColLast);
    end

    // Pixel history. It is not reset, because stale contents never reach a valid window.
    always_ff @(posedge clk) begin
        if (valid_in && !rst) begin
            for (int ch = 0; ch < 3; ch++) begin
                for (int i = 0; i < ChainLen - 1; i++) begin
                    chain_q[ch][i] <= chain_d[ch][i];
                end
            end
        end
    end

    // Counters, the registered window and the one-cycle strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            for (int ch = 0; ch < 3; ch++) begin
                for (int k = 0; k < 25; k++) begin
                    win_q[ch][k] <= '0;
                end
            end
        end else begin
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            if (valid_in) begin
                col_q <= col_d;
                row_q <= row_d;
                if (win_hit) begin
                    valid_q <= 1'b1;
                    done_q  <= frame_end;
                    for (int ch = 0; ch < 3; ch++) begin
                        for (int k = 0; k < 25; k++) begin
                            win_q[ch][k] <= win_d[ch][k];
                        end
                    end
                end
            end
        end
    end

    assign valid_out_buf = valid_q;
    assign frame_done    = done_q;

    assign data_out1_0  = win_q[0][0];
    assign data_out1_1  = win_q[0][1];
    assign data_out1_2  = win_q[0][2];
    assign data_out1_3  = win_q[0][3];
    assign data_out1_4  = win_q[0][4];
    assign data_out1_5  = win_q[0][5];
    assign data_out1_6  = win_q[0][6];
    assign data_out1_7  = win_q[0][7];
    assign data_out1_8  = win_q[0][8];
    assign data_out1_9  = win_q[0][9];
    assign data_out1_10 = win_q[0][10];
    assign data_out1_11 = win_q[0][11];
    assign data_out1_12 = win_q[0][12];
    assign data_out1_13 = win_q[0][13];
    assign data_out1_14 = win_q[0][14];
    assign data_out1_15 = win_q[0][15];
    assign data_out1_16 = win_q[0][16];
    assign data_out1_17 = win_q[0][17];
    assign data_out1_18 = win_q[0][18];
    assign data_out1_19 = win_q[0][19];
    assign data_out1_20 = win_q[0][20];
    assign data_out1_21 = win_q[0][21];
    assign data_out1_22 = win_q[0][22];
    assign data_out1_23 = win_q[0][23];
    assign data_out1_24 = win_q[0][24];
    assign data_out2_0  = win_q[1][0];
    assign data_out2_1  = win_q[1][1];
    assign data_out2_2  = win_q[1][2];
    assign data_out2_3  = win_q[1][3];
    assign data_out2_4  = win_q[1][4];
    assign data_out2_5  = win_q[1][5];
    assign data_out2_6  = win_q[1][6];
    assign data_out2_7  = win_q[1][7];
    assign data_out2_8  = win_q[1][8];
    assign data_out2_9  = win_q[1][9];
    assign data_out2_10 = win_q[1][10];
    assign data_out2_11 = win_q[1][11];
    assign data_out2_12 = win_q[1][12];
    assign data_out2_13 = win_q[1][13];
    assign data_out2_14 = win_q[1][14];
    assign data_out2_15 = win_q[1][15];
    assign data_out2_16 = win_q[1][16];
    assign data_out2_17 = win_q[1][17];
    assign data_out2_18 = win_q[1][18];
    assign data_out2_19 = win_q[1][19];
    assign data_out2_20 = win_q[1][20];
    assign data_out2_21 = win_q[1][21];
    assign data_out2_22 = win_q[1][22];
    assign data_out2_23 = win_q[1][23];
    assign data_out2_24 = win_q[1][24];
    assign data_out3_0  = win_q[2][0];
    assign data_out3_1  = win_q[2][1];
    assign data_out3_2  = win_q[2][2];
    assign data_out3_3  = win_q[2][3];
    assign data_out3_4  = win_q[2][4];
    assign data_out3_5  = win_q[2][5];
    assign data_out3_6  = win_q[2][6];
    assign data_out3_7  = win_q[2][7];
    assign data_out3_8  = win_q[2][8];
    assign data_out3_9  = win_q[2][9];
    assign data_out3_10 = win_q[2][10];
    assign data_out3_11 = win_q[2][11];
    assign data_out3_12 = win_q[2][12];
    assign data_out3_13 = win_q[2][13];
    assign data_out3_14 = win_q[2][14];
    assign data_out3_15 = win_q[2][15];
    assign data_out3_16 = win_q[2][16];
    assign data_out3_17 = win_q[2][17];
    assign data_out3_18 = win_q[2][18];
    assign data_out3_19 = win_q[2][19];
    assign data_out3_20 = win_q[2][20];
    assign data_out3_21 = win_q[2][21];
    assign data_out3_22 = win_q[2][22];
    assign data_out3_23 = win_q[2][23];
    assign data_out3_24 = win_q[2][24];

endmodule
